ni_target_resp_sched: RTL and testbench
=======================================

// Module: ni_target_resp_sched
// PURPOSE
// - Schedules the NI target's two response sources onto the single out_buffer write port (valid/full).
//   - Write-response packets (B path).
//   - Read-response packets (R path).
// - Packet-atomic round-robin: a granted source keeps the port from head flit to tail flit.
// - Sits between the response packetizers and out_buffer; runs in the NoC clock domain.
// PARAMETERS
// - FLIT_WIDTH  80  flit width in bits
// - STAT_WD     16  width of the statistics counters (RESP_SCHED_STATS_EN only)
// PORTS
// - clk            in   1           NoC clock
// - rst            in   1           asynchronous, active-high reset
// - wr_valid       in   1           B-path flit available
// - wr_flit        in   FLIT_WIDTH  B-path flit
// - wr_tail        in   1           current B-path flit is the last flit of its packet
// - wr_ready       out  1           B-path flit consumed this cycle
// - rd_valid       in   1           R-path flit available
// - rd_flit        in   FLIT_WIDTH  R-path flit
// - rd_tail        in   1           current R-path flit is the last flit of its packet
// - rd_ready       out  1           R-path flit consumed this cycle
// - flit           out  FLIT_WIDTH  flit to out_buffer data_in
// - valid          out  1           out_buffer write strobe
// - stall          in   1           out_buffer full
// - busy           out  1           a packet is in flight (state != IDLE)
// - wr_pkts        out  STAT_WD     B packets sent (RESP_SCHED_STATS_EN only)
// - rd_pkts        out  STAT_WD     R packets sent (RESP_SCHED_STATS_EN only)
// BEHAVIOUR
// - Reset values: state=IDLE, last_grant=RD (first contested grant goes to WR), all outputs 0.
// - States:
//   - IDLE -> WR_PKT or RD_PKT on the registered arbitration decision; no flit moves in IDLE.
//   - WR_PKT / RD_PKT -> IDLE when the tail flit transfers.
// - Arbitration in IDLE:
//   - Only one of wr_valid/rd_valid high: grant that source.
//   - Both high: grant the source opposite last_grant.
//   - last_grant is updated on each grant.
// - Transfer in XX_PKT (combinational):
//   - valid = xx_valid & ~stall; xx_ready = valid; flit = xx_flit.
//   - The non-granted source's ready is 0.
// - Latency: first flit leaves 1 cycle after the source raises valid (IDLE decision cycle).
//   - Following flits of the same packet: 1 per cycle while valid & ~stall.
// - Back-to-back packets pass through one IDLE cycle between tail and next head.
// - A source dropping valid mid-packet holds the grant; the other source waits and there is no timeout.
// - stall high: valid=0, ready=0, state and flit index unchanged.
//   - The flit stays on the source until stall drops.
// - Single-flit packet (tail on head): XX_PKT lasts 1 transfer cycle, then IDLE.
// - valid is never high while stall is high; flit is don't-care when valid=0, but muxed from the granted source.
// - Reset mid-packet: return to IDLE immediately, drop the partial packet, set last_grant=RD.
//   - Source packetizers are reset by the same rst.
// CONFIGURATION
// - RESP_SCHED_STATS_EN defined:
//   - wr_pkts/rd_pkts increment by 1 on each tail transfer of their source.
//   - Counters saturate at 2^STAT_WD-1 and reset to 0.
// - Not defined: wr_pkts/rd_pkts tied to 0 and no counter flops are inferred.
// TESTING
// - Reset; wr_valid=1 with a 3-flit packet, rd_valid=0, stall=0
//   -> valid high cycles 1..3, flits in order, wr_ready=1x3, busy 1..3, IDLE at cycle 4.
// - wr_valid and rd_valid both high from reset, 2-flit packets, repeated 4x
//   -> grant order WR,RD,WR,RD,...; no interleaving; one IDLE gap between packets.
// - RD packet of 4 flits, stall=1 during flit 2 for 5 cycles
//   -> valid=0 and rd_ready=0 for those 5 cycles; flit 2 is sent once after stall drops; flit count stays 4.
// - RD packet granted, rd_valid low 3 cycles mid-packet while wr_valid=1
//   -> wr_ready stays 0 until the RD tail transfers; WR is granted next.
// - rst asserted while flit 2 of 4 transfers
//   -> valid=0, busy=0 same cycle; after release with both valid, WR is granted first.
// - STATS_EN with STAT_WD=4; send 20 single-flit WR packets -> wr_pkts saturates at 15, rd_pkts=0.

Source files
------------

// File: rtl/ni_target_resp_sched.sv
// Packet-atomic round-robin scheduler that merges the NI target's B and R response flit streams onto one out_buffer write port.
// Optional packet statistics counters are built only when RESP_SCHED_STATS_EN is defined.
module ni_target_resp_sched #(
  parameter int FLIT_WIDTH = 80,
  parameter int STAT_WD    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [FLIT_WIDTH-1:0] wr_flit,
  input  logic                  wr_tail,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [FLIT_WIDTH-1:0] rd_flit,
  input  logic                  rd_tail,
  output logic                  rd_ready,
  output logic [FLIT_WIDTH-1:0] flit,
  output logic                  valid,
  input  logic                  stall,
  output logic                  busy,
  output logic [STAT_WD-1:0]    wr_pkts,
  output logic [STAT_WD-1:0]    rd_pkts
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PKT = 2'd1,
    RD_PKT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_rd_q, last_rd_d;   // 1: the most recent grant went to the R path

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      IDLE: begin
        // Contested request goes to the source opposite the previous grant.
        if (wr_valid && (!rd_valid || last_rd_q)) begin
          state_d   = WR_PKT;
          last_rd_d = 1'b0;
        end else if (rd_valid) begin
          state_d   = RD_PKT;
          last_rd_d = 1'b1;
        end
      end
      WR_PKT:  if (wr_ready && wr_tail) state_d = IDLE;
      RD_PKT:  if (rd_ready && rd_tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid    = 1'b0;
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    flit     = wr_flit;
    unique case (state_q)
      WR_PKT: begin
        valid    = wr_valid & ~stall;
        wr_ready = valid;
      end
      RD_PKT: begin
        valid    = rd_valid & ~stall;
        rd_ready = valid;
        flit     = rd_flit;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef RESP_SCHED_STATS_EN
  logic [STAT_WD-1:0] wr_pkts_q, wr_pkts_d;
  logic [STAT_WD-1:0] rd_pkts_q, rd_pkts_d;

  // Saturating packet counters, stepped on each tail transfer.
  always_comb begin
    wr_pkts_d = wr_pkts_q;
    rd_pkts_d = rd_pkts_q;
    if (wr_ready && wr_tail && (wr_pkts_q != '1)) wr_pkts_d = wr_pkts_q + STAT_WD'(1);
    if (rd_ready && rd_tail && (rd_pkts_q != '1)) rd_pkts_d = rd_pkts_q + STAT_WD'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pkts_q <= '0;
      rd_pkts_q <= '0;
    end else begin
      wr_pkts_q <= wr_pkts_d;
      rd_pkts_q <= rd_pkts_d;
    end
  end

  assign wr_pkts = wr_pkts_q;
  assign rd_pkts = rd_pkts_q;
`else
  assign wr_pkts = '0;
  assign rd_pkts = '0;
`endif

endmodule

// File: tb/tb_ni_target_resp_sched.sv
// Scoreboard bench for ni_target_resp_sched: directed packets, expected flit order queued at issue, monitor compares on valid.
module tb_ni_target_resp_sched;
  localparam int FW = 80;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0, rd_valid = 1'b0;
  logic [FW-1:0] wr_flit = '0, rd_flit = '0;
  logic          wr_tail = 1'b0, rd_tail = 1'b0;
  logic          wr_ready, rd_ready, valid, busy;
  logic          stall = 1'b0;
  logic [FW-1:0] flit;
  logic [SW-1:0] wr_pkts, rd_pkts;

  ni_target_resp_sched #(.FLIT_WIDTH(FW), .STAT_WD(SW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_flit(wr_flit), .wr_tail(wr_tail), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_flit(rd_flit), .rd_tail(rd_tail), .rd_ready(rd_ready),
    .flit(flit), .valid(valid), .stall(stall), .busy(busy),
    .wr_pkts(wr_pkts), .rd_pkts(rd_pkts)
  );

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] flit; logic tail; } src_t;
  typedef struct { logic [FW-1:0] flit; logic is_rd; } exp_t;

  src_t wq[$];
  src_t rq[$];
  exp_t expq[$];
  logic wr_pause = 1'b0, rd_pause = 1'b0;
  int   checks = 0, errors = 0, seen = 0;

`ifdef RESP_SCHED_STATS_EN
  localparam int EXP_WR_PKTS = 15;
`else
  localparam int EXP_WR_PKTS = 0;
`endif

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic is_rd, input int pkt, input int idx);
    logic [FW-1:0] f;
    f = '0;
    f[23:16] = is_rd ? 8'h52 : 8'h57;
    f[15:8]  = pkt[7:0];
    f[7:0]   = idx[7:0];
    return f;
  endfunction

  // Present the head of each source queue to the DUT.
  task automatic drive();
    wr_valid = (wq.size() > 0) && !wr_pause;
    wr_flit  = (wq.size() > 0) ? wq[0].flit : '0;
    wr_tail  = (wq.size() > 0) ? wq[0].tail : 1'b0;
    rd_valid = (rq.size() > 0) && !rd_pause;
    rd_flit  = (rq.size() > 0) ? rq[0].flit : '0;
    rd_tail  = (rq.size() > 0) ? rq[0].tail : 1'b0;
  endtask

  task automatic push_pkt(input logic is_rd, input int pkt, input int n);
    src_t s;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      s.flit = mk(is_rd, pkt, i);
      s.tail = (i == n - 1);
      e.flit = s.flit;
      e.is_rd = is_rd;
      if (is_rd) rq.push_back(s); else wq.push_back(s);
      expq.push_back(e);
    end
    drive();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    wq.delete(); rq.delete(); expq.delete();
    wr_pause = 1'b0; rd_pause = 1'b0; stall = 1'b0;
    drive();
    step();
    step();
    rst = 1'b0;
    seen = 0;
  endtask

  task automatic wait_seen(input int target, input int bound, output int n);
    n = 0;
    while (seen < target && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Source drivers: pop a flit once the DUT accepted it.
  initial begin
    logic wx, rx;
    forever begin
      @(negedge clk);
      wx = wr_ready;
      rx = rd_ready;
      @(posedge clk);
      #1;
      if (wx && wq.size() > 0) void'(wq.pop_front());
      if (rx && rq.size() > 0) void'(rq.pop_front());
      drive();
    end
  end

  // Monitor: every presented flit is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid) begin
        seen++;
        check("valid_under_stall", stall, 1'b0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit got=%0h expected=none at %0t", flit, $time);
        end else begin
          e = expq.pop_front();
          check("flit_order", flit, e.flit);
          check("ready_src", {wr_ready, rd_ready}, e.is_rd ? 2'b01 : 2'b10);
        end
      end
    end
  end

  initial begin
    int n;
    logic [4:0] exp_v;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    // Reset state
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {wr_ready, rd_ready}, 2'b00);
    check("rst_wr_pkts", wr_pkts, '0);
    check("rst_rd_pkts", rd_pkts, '0);

    // Single 3-flit WR packet: decision cycle, 3 transfer cycles, then IDLE.
    push_pkt(1'b0, 1, 3);
    exp_v = 5'b01110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t1_valid_c%0d", i), valid, exp_v[4-i]);
      check($sformatf("t1_busy_c%0d", i), busy, exp_v[4-i]);
      check($sformatf("t1_wr_ready_c%0d", i), wr_ready, exp_v[4-i]);
    end
    check("t1_done", expq.size(), 0);

    // Both sources loaded from reset: WR,RD alternation with one IDLE gap each.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_pkt(1'b0, 10 + k, 2);
      push_pkt(1'b1, 20 + k, 2);
    end
    wait_seen(16, 60, n);
    check("t2_flits", seen, 16);
    check("t2_cycles", n, 24);

    // RD 4-flit packet, stall for 5 cycles on flit 2.
    do_reset();
    push_pkt(1'b1, 30, 4);
    step();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("t3_stall_valid", valid, 1'b0);
      check("t3_stall_rd_ready", rd_ready, 1'b0);
      check("t3_stall_busy", busy, 1'b1);
    end
    check("t3_seen_before_release", seen, 2);
    step();
    stall = 1'b0;
    wait_seen(4, 20, n);
    repeat (4) @(negedge clk);
    #1;
    check("t3_flit_count", seen, 4);
    check("t3_done", expq.size(), 0);

    // RD source pauses mid-packet; WR must wait for the RD tail.
    do_reset();
    push_pkt(1'b1, 40, 3);
    step();
    push_pkt(1'b0, 41, 2);
    step();
    rd_pause = 1'b1;
    drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t4_pause_wr_ready", wr_ready, 1'b0);
      check("t4_pause_valid", valid, 1'b0);
      check("t4_pause_busy", busy, 1'b1);
    end
    step();
    rd_pause = 1'b0;
    drive();
    wait_seen(5, 40, n);
    check("t4_flits", seen, 5);
    check("t4_done", expq.size(), 0);

    // Reset while flit 2 of a WR packet is on the port.
    do_reset();
    push_pkt(1'b0, 50, 4);
    step();
    step();
    step();
    check("t5_pre_valid", valid, 1'b1);
    check("t5_pre_flit", flit, mk(1'b0, 50, 2));
    rst = 1'b1;
    #1;
    check("t5_rst_valid", valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    wq.delete(); rq.delete(); expq.delete();
    drive();
    step();
    rst = 1'b0;
    seen = 0;
    push_pkt(1'b0, 51, 1);
    push_pkt(1'b1, 52, 1);
    wait_seen(2, 20, n);
    check("t5_after_rst", seen, 2);

    // 20 single-flit WR packets: counter saturates (stats build) or stays 0.
    do_reset();
    for (int k = 0; k < 20; k++) push_pkt(1'b0, 60 + k, 1);
    wait_seen(20, 100, n);
    @(negedge clk);
    #1;
    check("t6_flits", seen, 20);
    check("t6_wr_pkts", wr_pkts, EXP_WR_PKTS);
    check("t6_rd_pkts", rd_pkts, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
